// File: rtl/pimsynth_shift_pkg.sv
// Shared constants and operand-pair type for the shift_l pipeline.
package pimsynth_shift_pkg;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int WIDTH       = 16;
  localparam int SHIFT_WIDTH = clog2_f(WIDTH);
  localparam int FIFO_DEPTH  = 2;
  localparam int OCC_WIDTH   = clog2_f(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } operand_pair_t;

endpackage

// File: rtl/shift_l_nbit.sv
// Combinational logical left shift; vacated LSBs fill with zero.
module shift_l_nbit #(
  parameter int WIDTH       = 16,
  parameter int SHIFT_WIDTH = 4
) (
  input  logic [WIDTH-1:0]       a,
  input  logic [SHIFT_WIDTH-1:0] sh,
  output logic [WIDTH-1:0]       y
);
  assign y = a << sh;
endmodule

// File: rtl/shift_l_operand_fifo.sv
// Generic valid/ready FIFO with occupancy count; DEPTH must be a power of two.
module shift_l_operand_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     pop_valid,
  input  logic                     pop_ready,
  output logic [DATA_W-1:0]        pop_data,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Flags derive from registered occupancy only, so no path from pop_ready to push_ready.
  assign push_ready = (occupancy != OCC_W'(DEPTH));
  assign pop_valid  = (occupancy != '0);
  assign pop_data   = mem[rd_ptr];
  assign push       = push_valid && push_ready;
  assign pop        = pop_valid && pop_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/shift_l_pipe_int16.sv
// Elastic wrapper: 2-entry operand FIFO, shifter on the FIFO head, registered result stage.
// Define SHIFT_L_PIPE_OVF_EN to add the out_ovf overflow flag.
module shift_l_pipe_int16
  import pimsynth_shift_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
`ifdef SHIFT_L_PIPE_OVF_EN
  output logic                 out_ovf,
`endif
  output logic [OCC_WIDTH-1:0] occupancy
);
  operand_pair_t          in_pair;
  operand_pair_t          head;
  logic                   head_valid;
  logic                   out_free;
  logic                   load;
  logic [WIDTH-1:0]       shift_y;
  logic [SHIFT_WIDTH-1:0] head_sh;
  logic                   b_unused;

  assign in_pair.a = in_a;
  assign in_pair.b = in_b;
  assign out_free  = !out_valid || out_ready;
  assign load      = head_valid && out_free;
  assign head_sh   = head.b[SHIFT_WIDTH-1:0];
  assign b_unused  = ^head.b[WIDTH-1:SHIFT_WIDTH];

  shift_l_operand_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W ($bits(operand_pair_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_valid (in_valid),
    .push_ready (in_ready),
    .push_data  (in_pair),
    .pop_valid  (head_valid),
    .pop_ready  (out_free),
    .pop_data   (head),
    .occupancy  (occupancy)
  );

  shift_l_nbit #(
    .WIDTH       (WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shift (
    .a  (head.a),
    .sh (head_sh),
    .y  (shift_y)
  );

`ifdef SHIFT_L_PIPE_OVF_EN
  logic head_ovf;
  // The top sh bits of A are the ones pushed past the MSB.
  assign head_ovf = |(head.a & ~({WIDTH{1'b1}} >> head_sh));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       out_ovf <= 1'b0;
    else if (load) out_ovf <= head_ovf;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_y     <= shift_y;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_l_pipe_int16.sv
// Self-checking bench for shift_l_pipe_int16: directed table, corner sequences, random traffic.
module tb_shift_l_pipe_int16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_y;
  logic [1:0]  occupancy;
`ifdef SHIFT_L_PIPE_OVF_EN
  logic        out_ovf;
`endif

  shift_l_pipe_int16 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
`ifdef SHIFT_L_PIPE_OVF_EN
    .out_ovf   (out_ovf),
`endif
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: operand queue plus the output register contents.
  logic [15:0] q_a[$];
  logic [15:0] q_b[$];
  bit          m_valid;
  logic [15:0] m_y;
  bit          m_ovf;
  bit          last_push;
  logic [15:0] got_q[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] y;
    logic        ovf;
  } vec_t;

  function automatic longint full_product(input logic [15:0] a, input logic [15:0] b);
    int sh;
    sh = int'(b) % 16;
    return longint'(a) * (longint'(1) << sh);
  endfunction

  function automatic logic [15:0] ref_y(input logic [15:0] a, input logic [15:0] b);
    return 16'(full_product(a, b) % 65536);
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b);
    return full_product(a, b) >= 65536;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    q_a.delete();
    q_b.delete();
    m_valid = 0;
    m_y     = '0;
    m_ovf   = 0;
  endtask

  task automatic model_step();
    bit push;
    bit pop;
    if (out_valid === 1'b1 && out_ready) got_q.push_back(out_y);
    push = in_valid && (q_a.size() < 2);
    pop  = (q_a.size() != 0) && (!m_valid || out_ready);
    if (pop) begin
      m_y     = ref_y(q_a[0], q_b[0]);
      m_ovf   = ref_ovf(q_a[0], q_b[0]);
      m_valid = 1;
      void'(q_a.pop_front());
      void'(q_b.pop_front());
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
    if (push) begin
      q_a.push_back(in_a);
      q_b.push_back(in_b);
    end
    last_push = push;
  endtask

  task automatic check_state();
    check("out_valid", out_valid, m_valid);
    check("out_y", out_y, m_y);
    check("occupancy", occupancy, q_a.size());
    check("in_ready", in_ready, q_a.size() < 2);
`ifdef SHIFT_L_PIPE_OVF_EN
    check("out_ovf", out_ovf, m_ovf);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic assert_reset();
    in_valid = 0;
    rst = 1;
    #1;
    model_clear();
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_y", out_y, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  vec_t        vecs[9];
  int          idx;
  int          pushed;
  int          cyc;
  int          mism;
  logic [15:0] held;
  bit          have_held;
  logic [15:0] sent_y[$];

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; in_a = '0; in_b = '0;
    vecs[0] = '{16'h0001, 16'h0004, 16'h0010, 1'b0};
    vecs[1] = '{16'h8001, 16'h0001, 16'h0002, 1'b1};
    vecs[2] = '{16'h1234, 16'hFFF0, 16'h1234, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h000F, 16'h8000, 1'b1};
    vecs[4] = '{16'h0001, 16'h000F, 16'h8000, 1'b0};
    vecs[5] = '{16'hABCD, 16'h0000, 16'hABCD, 1'b0};
    vecs[6] = '{16'h00FF, 16'h0008, 16'hFF00, 1'b0};
    vecs[7] = '{16'h0F0F, 16'h0014, 16'hF0F0, 1'b0};
    vecs[8] = '{16'hC000, 16'h0002, 16'h0000, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    assert_reset();
    check_state();

    // Directed table: result appears one edge after accept, valid for exactly one cycle.
    out_ready = 1;
    foreach (vecs[i]) begin
      in_valid = 1; in_a = vecs[i].a; in_b = vecs[i].b;
      cycle();
      in_valid = 0;
      check("tbl_not_yet", out_valid, 0);
      cycle();
      check("tbl_valid", out_valid, 1);
      check("tbl_y", out_y, vecs[i].y);
`ifdef SHIFT_L_PIPE_OVF_EN
      check("tbl_ovf", out_ovf, vecs[i].ovf);
`endif
      cycle();
      check("tbl_one_cycle", out_valid, 0);
    end

    // Back-to-back: 8 pairs, one result per cycle, in_ready never drops.
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_a = 16'(i); in_b = 16'(i);
      check("b2b_in_ready", in_ready, 1);
      cycle();
    end
    in_valid = 0;
    repeat (3) cycle();
    check("b2b_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check("b2b_y", got_q[i], 16'(i << i));

    // Output stall while pushing: 3 accepted, output held, then in-order drain.
    got_q.delete();
    out_ready = 0;
    idx = 0;
    have_held = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4); in_a = 16'h0100 + 16'(idx); in_b = 16'(idx + 1);
      cycle();
      if (last_push) idx++;
      if (out_valid) begin
        if (!have_held) begin held = out_y; have_held = 1; end
        else check("stall_hold", out_y, held);
      end
    end
    check("stall_accepted", idx, 3);
    check("stall_in_ready", in_ready, 0);
    check("stall_occ", occupancy, 2);
    in_valid = 0;
    out_ready = 1;
    repeat (5) cycle();
    check("stall_drain_count", got_q.size(), 3);
    for (int k = 0; k < 3 && k < got_q.size(); k++)
      check("stall_drain_y", got_q[k], ref_y(16'h0100 + 16'(k), 16'(k + 1)));

    // Reset with FIFO full and result pending: all discarded.
    out_ready = 0;
    in_valid = 1;
    for (int c = 0; c < 4; c++) begin
      in_a = 16'h7000 + 16'(c); in_b = 16'(c);
      cycle();
    end
    check("prerst_valid", out_valid, 1);
    check("prerst_occ", occupancy, 2);
    assert_reset();
    out_ready = 1;
    got_q.delete();
    repeat (5) cycle();
    check("postrst_no_output", got_q.size(), 0);

    // Random traffic against the model.
    got_q.delete();
    sent_y.delete();
    pushed = 0;
    cyc = 0;
    in_a = 16'($urandom); in_b = 16'($urandom);
    while (pushed < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      cyc++;
      if (last_push) begin
        sent_y.push_back(ref_y(in_a, in_b));
        pushed++;
        in_a = 16'($urandom); in_b = 16'($urandom);
      end
    end
    check("rand_pushed", pushed, 10000);
    in_valid = 0;
    out_ready = 1;
    repeat (6) cycle();
    check("rand_count", got_q.size(), sent_y.size());
    mism = 0;
    for (int k = 0; k < sent_y.size() && k < got_q.size(); k++)
      if (got_q[k] !== sent_y[k]) mism++;
    check("rand_order", mism, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
